// File: rtl/piece_drop_ctrl.sv
// Falling-piece controller: requests a shape, moves it under gravity and player input,
// locks it into a 12x12 board, clears full rows and flags a blocked spawn.

// Next-value of one board row during a line clear: rows at or above the full row
// take the row above them, the top row empties, rows below hold.
module pdc_row_shift #(
    parameter int COLS  = 12,
    parameter int IDX   = 0,
    parameter int PTR_W = 4
) (
    input  logic [PTR_W-1:0] ptr,
    input  logic [COLS-1:0]  row_cur,
    input  logic [COLS-1:0]  row_above,
    output logic [COLS-1:0]  row_next
);
    always_comb begin
        row_next = row_cur;
        if (IDX == 0)
            row_next = '0;
        else if (PTR_W'(IDX) <= ptr)
            row_next = row_above;
    end
endmodule

module piece_drop_ctrl #(
    parameter int ROWS  = 12,
    parameter int COLS  = 12,
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [ROWS*COLS:0]   new_shape,
    input  logic                 drop_tick,
    input  logic                 move_left,
    input  logic                 move_right,
    output logic                 refresh,
    output logic [ROWS*COLS:0]   board,
    output logic [ROWS*COLS:0]   piece,
    output logic [ROWS*COLS:0]   display,
    output logic [CNT_W-1:0]     lines_cleared,
    output logic                 game_over
);
    localparam int N     = ROWS * COLS;
    localparam int PTR_W = $clog2(ROWS);

    function automatic logic [N-1:0] col_mask(input int c);
        logic [N-1:0] m;
        m = '0;
        for (int r = 0; r < ROWS; r++)
            m[r*COLS + c] = 1'b1;
        return m;
    endfunction

    localparam logic [N-1:0] COL_FIRST = col_mask(0);
    localparam logic [N-1:0] COL_LAST  = col_mask(COLS - 1);
    localparam logic [N-1:0] ROW_LAST  = {{COLS{1'b1}}, {(N-COLS){1'b0}}};

    typedef enum logic [2:0] {
        S_REQ   = 3'd0,
        S_LOAD  = 3'd1,
        S_FALL  = 3'd2,
        S_CLEAR = 3'd3,
        S_OVER  = 3'd4
    } state_t;

    state_t               state_q;
    logic [N-1:0]         brd_q;
    logic [N-1:0]         pc_q;
    logic [PTR_W-1:0]     ptr_q;
    logic [CNT_W-1:0]     cnt_q;
    logic                 go_q;
    logic                 ref_q;

    // The extra top bit of the shape bus carries no cell.
    logic                 shape_msb_unused;
    assign shape_msb_unused = new_shape[N];

    logic [N-1:0] pc_down, pc_left, pc_right;
    logic         can_down, can_left, can_right, spawn_hit;

    assign pc_down   = pc_q << COLS;
    assign pc_left   = pc_q >> 1;
    assign pc_right  = pc_q << 1;
    assign can_down  = ~|(pc_q & ROW_LAST)  && ~|(pc_down  & brd_q);
    assign can_left  = ~|(pc_q & COL_FIRST) && ~|(pc_left  & brd_q);
    assign can_right = ~|(pc_q & COL_LAST)  && ~|(pc_right & brd_q);
    assign spawn_hit = |(new_shape[N-1:0] & brd_q);

    logic [ROWS-1:0][COLS-1:0] rows_q, rows_above, rows_nxt;
    logic                      row_full;

    assign rows_q     = brd_q;
    assign rows_above = {rows_q[ROWS-2:0], {COLS{1'b0}}};
    assign row_full   = &rows_q[ptr_q];

    for (genvar g = 0; g < ROWS; g++) begin : g_row
        pdc_row_shift #(
            .COLS  (COLS),
            .IDX   (g),
            .PTR_W (PTR_W)
        ) u_shift (
            .ptr       (ptr_q),
            .row_cur   (rows_q[g]),
            .row_above (rows_above[g]),
            .row_next  (rows_nxt[g])
        );
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_REQ;
            brd_q   <= '0;
            pc_q    <= '0;
            ptr_q   <= PTR_W'(ROWS - 1);
            cnt_q   <= '0;
            go_q    <= 1'b0;
            ref_q   <= 1'b0;
        end else begin
            ref_q <= 1'b0;
            case (state_q)
                // Out of reset REQ first raises refresh; the cycle refresh is high
                // is the one the initializer samples, after which LOAD follows.
                S_REQ: begin
                    if (ref_q)
                        state_q <= S_LOAD;
                    else
                        ref_q <= 1'b1;
                end
                S_LOAD: begin
                    pc_q <= new_shape[N-1:0];
                    if (spawn_hit) begin
                        go_q    <= 1'b1;
                        state_q <= S_OVER;
                    end else begin
                        state_q <= S_FALL;
                    end
                end
                S_FALL: begin
                    if (drop_tick) begin
                        if (can_down) begin
                            pc_q <= pc_down;
                        end else begin
                            brd_q   <= brd_q | pc_q;
                            pc_q    <= '0;
                            ptr_q   <= PTR_W'(ROWS - 1);
                            state_q <= S_CLEAR;
                        end
                    end else if (move_left) begin
                        if (can_left)
                            pc_q <= pc_left;
                    end else if (move_right) begin
                        if (can_right)
                            pc_q <= pc_right;
                    end
                end
                // A full row collapses and the same index is rescanned.
                S_CLEAR: begin
                    if (row_full) begin
                        brd_q <= rows_nxt;
                        cnt_q <= cnt_q + CNT_W'(1);
                    end else if (ptr_q == '0) begin
                        state_q <= S_REQ;
                        ref_q   <= 1'b1;
                    end else begin
                        ptr_q <= ptr_q - PTR_W'(1);
                    end
                end
                S_OVER: ;
                default: state_q <= S_REQ;
            endcase
        end
    end

    assign refresh       = ref_q;
    assign board         = {1'b0, brd_q};
    assign piece         = {1'b0, pc_q};
    assign display       = {1'b0, brd_q | pc_q};
    assign lines_cleared = cnt_q;
    assign game_over     = go_q;
endmodule
